// File: rtl/pupil_pkg.sv
// rtl/pupil_pkg.sv - shared defaults and scan-controller state encoding for the pupil pipeline
package pupil_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_IMG_W      = 317;
   localparam int DEF_IMG_H      = 240;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACTIVE  = 2'd1;
   localparam logic [1:0] ST_GAP_ERR = 2'd2;
   localparam logic [1:0] ST_DRAIN   = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      ACTIVE  = ST_ACTIVE,
      GAP_ERR = ST_GAP_ERR,
      DRAIN   = ST_DRAIN
   } scan_state_t;

endpackage

// File: rtl/tag_delay.sv
// rtl/tag_delay.sv - LAT-stage shift register aligning window tags with the window datapath
module tag_delay #(
   parameter int LAT = 1,
   parameter int W   = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (LAT == 0) begin : g_bypass
         assign q = d;
      end else begin : g_pipe
         logic [W-1:0] stage_q [LAT];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
            end else begin
               stage_q[0] <= d;
               for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign q = stage_q[LAT-1];
      end
   endgenerate

endmodule

// File: rtl/window_scan_ctrl.sv
// rtl/window_scan_ctrl.sv - raster-scan sequencer feeding the 3x3 window datapath and qualifying its outputs
module window_scan_ctrl
   import pupil_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int IMG_W      = DEF_IMG_W,
   parameter int IMG_H      = DEF_IMG_H,
   parameter int COL_W      = 9,
   parameter int ROW_W      = 8,
   parameter int WIN_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sof,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  feed_valid,
   output logic [DATA_WIDTH-1:0] feed_data,
   output logic                  win_valid,
   output logic [ROW_W-1:0]      win_row,
   output logic [COL_W-1:0]      win_col,
   output logic                  win_last,
   output logic                  frame_done,
   output logic                  err_gap,
   output logic                  busy
);

   localparam int TAG_W = ROW_W + COL_W + 2;
   localparam int DCW   = $clog2(WIN_LAT + 2);
   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_H - 1);
   localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(WIN_LAT);

   scan_state_t           state_q, state_d;
   logic [COL_W-1:0]      col_q, col_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic [DCW-1:0]        drain_q, drain_d;
   logic                  err_q, err_d;
   logic                  done_q, done_d;
   logic                  take;
   logic [ROW_W-1:0]      pos_row;
   logic [COL_W-1:0]      pos_col;
   logic                  win_here;
   logic [TAG_W-1:0]      tag_d, tag_q, tag_out;
   logic                  feed_valid_q;
   logic [DATA_WIDTH-1:0] feed_data_q;

   // col/row hold the position the next accepted beat will occupy
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      drain_d = drain_q;
      err_d   = err_q;
      done_d  = 1'b0;
      take    = 1'b0;
      pos_row = '0;
      pos_col = '0;
      case (state_q)
         IDLE, GAP_ERR: begin
            if (in_valid && sof) begin
               take    = 1'b1;
               col_d   = COL_W'(1);
               row_d   = '0;
               err_d   = 1'b0;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (in_valid) begin
               take = 1'b1;
               if (sof) begin
                  col_d = COL_W'(1);
                  row_d = '0;
               end else begin
                  pos_row = row_q;
                  pos_col = col_q;
                  if (col_q == COL_LAST) begin
                     col_d = '0;
                     if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        drain_d = '0;
                        state_d = DRAIN;
                     end else begin
                        row_d = row_q + 1'b1;
                     end
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            end else if (col_q != '0) begin
               err_d   = 1'b1;
               state_d = GAP_ERR;
            end
         end
         DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // a beat completes a window once two full rows and two columns precede it
   always_comb begin
      win_here = take && (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));
      tag_d    = '0;
      if (win_here) begin
         tag_d = {1'b1, pos_row - ROW_W'(1), pos_col - COL_W'(1),
                  (pos_row == ROW_LAST) && (pos_col == COL_LAST)};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         drain_q      <= '0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
         feed_valid_q <= 1'b0;
         feed_data_q  <= '0;
         tag_q        <= '0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         drain_q      <= drain_d;
         err_q        <= err_d;
         done_q       <= done_d;
         feed_valid_q <= take;
         feed_data_q  <= take ? in_data : '0;
         tag_q        <= tag_d;
      end
   end

   tag_delay #(
      .LAT (WIN_LAT),
      .W   (TAG_W)
   ) u_tag_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (tag_q),
      .q     (tag_out)
   );

   assign in_ready   = (state_q != DRAIN);
   assign busy       = (state_q != IDLE);
   assign err_gap    = err_q;
   assign frame_done = done_q;
   assign feed_valid = feed_valid_q;
   assign feed_data  = feed_data_q;
   assign win_valid  = tag_out[TAG_W-1];
   assign win_row    = tag_out[TAG_W-2 -: ROW_W];
   assign win_col    = tag_out[COL_W:1];
   assign win_last   = tag_out[0];

endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb/tb_window_scan_ctrl.sv - randomized bench for window_scan_ctrl against a beat-level frame model
module tb_window_scan_ctrl;

   localparam int DW      = 8;
   localparam int IMG_W   = 5;
   localparam int IMG_H   = 4;
   localparam int COL_W   = 3;
   localparam int ROW_W   = 3;
   localparam int WIN_LAT = 1;
   localparam int N       = IMG_W * IMG_H;
   localparam int MAXC    = 3000;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             sof;
   logic             in_valid;
   logic [DW-1:0]    in_data;
   logic             in_ready;
   logic             feed_valid;
   logic [DW-1:0]    feed_data;
   logic             win_valid;
   logic [ROW_W-1:0] win_row;
   logic [COL_W-1:0] win_col;
   logic             win_last;
   logic             frame_done;
   logic             err_gap;
   logic             busy;

   window_scan_ctrl #(
      .DATA_WIDTH (DW),
      .IMG_W      (IMG_W),
      .IMG_H      (IMG_H),
      .COL_W      (COL_W),
      .ROW_W      (ROW_W),
      .WIN_LAT    (WIN_LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sof        (sof),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .feed_valid (feed_valid),
      .feed_data  (feed_data),
      .win_valid  (win_valid),
      .win_row    (win_row),
      .win_col    (win_col),
      .win_last   (win_last),
      .frame_done (frame_done),
      .err_gap    (err_gap),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // expected outputs, indexed by cycle number
   bit       e_fv   [MAXC];
   bit [7:0] e_fd   [MAXC];
   bit       e_wv   [MAXC];
   int       e_wr   [MAXC];
   int       e_wc   [MAXC];
   bit       e_wl   [MAXC];
   bit       e_done [MAXC];

   int t         = 0;
   int pix       = 0;
   bit in_frame  = 0;
   bit merr      = 0;
   int drain_end = -1;
   int obs_win, obs_last, obs_done;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, t, act, exp);
      end
   endtask

   task automatic clr_obs();
      obs_win  = 0;
      obs_last = 0;
      obs_done = 0;
   endtask

   // one clock cycle: entered and left #1 after a rising edge
   task automatic cyc(input bit v, input bit s, input bit do_rst);
      logic [DW-1:0] d;
      bit rdy;
      int r, c;
      if (t >= MAXC - 8) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", t, MAXC - 8);
         $fatal(1, "cycle budget exhausted");
      end
      d        = DW'($urandom);
      in_valid = v;
      sof      = s;
      in_data  = d;
      rst_n    = !do_rst;
      if (do_rst) begin
         #1;
         chk("rst_outs", {feed_valid, feed_data, win_valid, win_row, win_col, win_last,
                          frame_done, err_gap, busy}, '0);
         chk("rst_ready", in_ready, 1);
         for (int i = t; i < t + WIN_LAT + 4; i++) begin
            e_fv[i] = 0; e_fd[i] = 0; e_wv[i] = 0; e_wr[i] = 0; e_wc[i] = 0;
            e_wl[i] = 0; e_done[i] = 0;
         end
         in_frame  = 0;
         merr      = 0;
         drain_end = -1;
      end
      @(negedge clk);
      rdy = (t > drain_end);
      chk("feed_valid", feed_valid, e_fv[t]);
      chk("feed_data",  feed_data,  e_fd[t]);
      chk("win_valid",  win_valid,  e_wv[t]);
      chk("win_row",    win_row,    e_wr[t]);
      chk("win_col",    win_col,    e_wc[t]);
      chk("win_last",   win_last,   e_wl[t]);
      chk("frame_done", frame_done, e_done[t]);
      chk("in_ready",   in_ready,   rdy);
      chk("busy",       busy,       in_frame || merr || !rdy);
      chk("err_gap",    err_gap,    merr);
      obs_win  += int'(win_valid);
      obs_last += int'(win_valid && win_last);
      obs_done += int'(frame_done);
      if (!do_rst) begin
         if (rdy && v) begin
            if (s) begin
               pix      = 0;
               in_frame = 1;
               merr     = 0;
            end
            if (in_frame) begin
               e_fv[t+1] = 1;
               e_fd[t+1] = d;
               r = pix / IMG_W;
               c = pix % IMG_W;
               if (r >= 2 && c >= 2) begin
                  e_wv[t+1+WIN_LAT] = 1;
                  e_wr[t+1+WIN_LAT] = r - 1;
                  e_wc[t+1+WIN_LAT] = c - 1;
                  e_wl[t+1+WIN_LAT] = (pix == N - 1);
               end
               pix++;
               if (pix == N) begin
                  in_frame               = 0;
                  drain_end              = t + 1 + WIN_LAT;
                  e_done[t + 2 + WIN_LAT] = 1;
               end
            end
         end else if (rdy && !v && in_frame && (pix % IMG_W) != 0) begin
            merr     = 1;
            in_frame = 0;
         end
      end
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0);
   endtask

   // gm: 0 no line gaps, 1 three-cycle gaps, 2 random 0..3-cycle gaps
   task automatic frame(input int nb, input int gm);
      int g;
      for (int i = 0; i < nb; i++) begin
         cyc(1, i == 0, 0);
         if (((i + 1) % IMG_W) == 0 && (i + 1) < nb) begin
            g = (gm == 1) ? 3 : (gm == 2) ? int'($urandom_range(0, 3)) : 0;
            repeat (g) cyc(0, 0, 0);
         end
      end
   endtask

   initial begin
      int nb;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      sof      = 1'b0;
      in_data  = '0;
      clr_obs();
      repeat (2) @(posedge clk);
      #1;

      repeat (3) cyc(1, 0, 0);

      clr_obs();
      frame(N, 0);
      idle(WIN_LAT + 4);
      chk("cont_wins", obs_win, 6);
      chk("cont_last", obs_last, 1);
      chk("cont_done", obs_done, 1);

      clr_obs();
      frame(N, 1);
      idle(WIN_LAT + 4);
      chk("linegap_wins", obs_win, 6);
      chk("linegap_done", obs_done, 1);

      clr_obs();
      frame(8, 0);
      idle(3);
      repeat (3) cyc(1, 0, 0);
      chk("midgap_err", err_gap, 1);
      chk("midgap_wins", obs_win, 0);
      frame(N, 0);
      idle(WIN_LAT + 4);
      chk("midgap_recover_wins", obs_win, 6);
      chk("midgap_recover_done", obs_done, 1);

      clr_obs();
      frame(13, 0);
      frame(N, 0);
      idle(WIN_LAT + 4);
      chk("restart_wins", obs_win, 7);
      chk("restart_done", obs_done, 1);

      clr_obs();
      frame(15, 0);
      cyc(0, 0, 1);
      repeat (3) cyc(1, 0, 0);
      chk("post_rst_busy", busy, 0);
      frame(N, 0);
      idle(WIN_LAT + 4);
      chk("post_rst_done", obs_done, 1);

      repeat (25) begin
         repeat ($urandom_range(0, 3)) cyc(1'($urandom_range(0, 1)), 0, 0);
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 1)) : N;
         frame(nb, 2);
         if (nb == N) idle(WIN_LAT + 3);
         else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) cyc(0, 0, 1);
      end
      idle(WIN_LAT + 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
